// File: rtl/mvm_pkg.sv
// mvm_pkg: shared widths, bus bit positions and FSM states for the matrix-vector multiplier
package mvm_pkg;
   localparam int VEC_W      = 6;
   localparam int BUS_W      = 8;
   localparam int RES_W      = 8;
   localparam int STROBE_BIT = 0;
   localparam int VEC_LSB    = 2;
   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;
endpackage

// File: rtl/mvm_vec_fifo.sv
// mvm_vec_fifo: operand queue; registered storage and pointers, head word presented directly
module mvm_vec_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wr_data,
   input  logic         pop,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         wr_en, rd_en;
   // extra pointer bit separates full from empty when the indices match
   assign full    = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
   assign empty   = wr_q == rd_q;
   assign wr_en   = push && !full;
   assign rd_en   = pop && !empty;
   assign rd_data = mem_q[rd_q[AW-1:0]];
   always_comb begin
      wr_d = wr_en ? wr_q + 1'b1 : wr_q;
      rd_d = rd_en ? rd_q + 1'b1 : rd_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/mvm_toggle_tx.sv
// mvm_toggle_tx: queues operand vectors, launches them on the toggle-strobe bus,
// waits a fixed settle time and returns the captured result with its operand.
module mvm_toggle_tx
   import mvm_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [VEC_W-1:0] in_vec,
   output logic [BUS_W-1:0] bus_vec,
   input  logic [RES_W-1:0] bus_res,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic [VEC_W-1:0] res_vec,
   output logic             busy
);
   localparam int CW = $clog2(SETTLE_CYCLES) + 1;
   state_e           state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d, res_vec_q, res_vec_d, head;
   logic [RES_W-1:0] res_data_q, res_data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             strobe_q, strobe_d, res_valid_q, res_valid_d;
   logic             fifo_full, fifo_empty, launch, capture, consume;
   mvm_vec_fifo #(.W(VEC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (in_valid),
      .wr_data (in_vec),
      .pop     (launch),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );
   assign consume = state_q == HOLD && res_ready;
   assign launch  = !fifo_empty && (state_q == IDLE || consume);
   assign capture = state_q == WAIT && cnt_q == '0;
   always_comb begin
      state_d     = launch ? WAIT : capture ? HOLD : consume ? IDLE : state_q;
      vec_d       = launch ? head : vec_q;
      strobe_d    = strobe_q ^ launch;
      cnt_d       = launch ? CW'(SETTLE_CYCLES - 1) : (state_q == WAIT && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      res_valid_d = capture ? 1'b1 : consume ? 1'b0 : res_valid_q;
      res_data_d  = capture ? bus_res : res_data_q;
      res_vec_d   = capture ? vec_q : res_vec_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         strobe_q    <= 1'b0;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_vec_q   <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         strobe_q    <= strobe_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_vec_q   <= res_vec_d;
      end
   end
   always_comb begin
      bus_vec                       = '0;
      bus_vec[VEC_LSB +: VEC_W]     = vec_q;
      bus_vec[STROBE_BIT]           = strobe_q;
   end
   assign in_ready  = !fifo_full;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_vec   = res_vec_q;
   assign busy      = state_q != IDLE || !fifo_empty;
endmodule

// File: tb/tb_mvm_toggle_tx.sv
// tb_mvm_toggle_tx: directed checks of mvm_toggle_tx with a combinational stub multiplier
module tb_mvm_toggle_tx;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       in_valid, in_ready, res_valid, res_ready, busy;
   logic [5:0] in_vec, res_vec;
   logic [7:0] bus_vec, bus_res, res_data;
   logic       in_valid1, in_ready1, res_valid1, res_ready1, busy1;
   logic [5:0] in_vec1, res_vec1;
   logic [7:0] bus_vec1, bus_res1, res_data1;
   int         passed = 0, total = 0, tog = 0;
   logic       prev_s = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [7:0] mm(input logic [5:0] v);
      logic [7:0] r [6];
      logic [7:0] s;
      r = '{8'h01, 8'h12, 8'h24, 8'h48, 8'h90, 8'h3C};
      s = 8'h00;
      for (int i = 0; i < 6; i++) if (v[i]) s += r[i];
      return s;
   endfunction

   assign bus_res  = mm(bus_vec[7:2]);
   assign bus_res1 = mm(bus_vec1[7:2]);

   mvm_toggle_tx dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .bus_vec(bus_vec), .bus_res(bus_res), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_vec(res_vec), .busy(busy)
   );

   mvm_toggle_tx #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
      .bus_vec(bus_vec1), .bus_res(bus_res1), .res_valid(res_valid1), .res_ready(res_ready1),
      .res_data(res_data1), .res_vec(res_vec1), .busy(busy1)
   );

   always @(negedge clk) begin
      if (bus_vec[0] !== prev_s) tog++;
      prev_s = bus_vec[0];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic [5:0] bp [6];
      logic [7:0] bpr [6];
      logic [5:0] q [$];
      logic [5:0] e;
      logic       s, acc, acc5;
      int         n, np, nr, t0;
      bp  = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
      bpr = '{8'h01, 8'h12, 8'h24, 8'h48, 8'h90, 8'h3C};
      in_valid = 0; in_vec = 0; res_ready = 0;
      in_valid1 = 0; in_vec1 = 0; res_ready1 = 1;
      tick; tick;
      chk("rst_bus", bus_vec, 8'h00);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_data", res_data, 8'h00);
      chk("rst_res_vec", res_vec, 6'h00);
      rst_n = 1; tick;
      // single transaction: accepted at E, launched at E+1, result after E+4
      in_valid = 1; in_vec = 6'h01; tick;
      in_valid = 0;
      chk("single_busy", busy, 1);
      chk("single_pre_bus", bus_vec, 8'h00);
      tick;
      chk("single_bus", bus_vec, 8'h05);
      tick; tick;
      chk("single_early", res_valid, 0);
      tick;
      chk("single_valid", res_valid, 1);
      chk("single_data", res_data, 8'h01);
      chk("single_vec", res_vec, 6'h01);
      res_ready = 1; tick;
      chk("single_done", res_valid, 0);
      chk("single_idle", busy, 0);
      res_ready = 0;
      // reset with one operand in flight and one queued
      in_valid = 1; in_vec = 6'h02; tick;
      in_vec = 6'h04; tick;
      in_valid = 0; tick;
      chk("mid_bus", bus_vec, 8'h08);
      rst_n = 0; tick;
      chk("mid_rst_bus", bus_vec, 8'h00);
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      rst_n = 1;
      repeat (6) tick;
      chk("flush_busy", busy, 0);
      chk("flush_bus", bus_vec, 8'h00);
      chk("flush_valid", res_valid, 0);
      // three identical operands: launches at E+1, E+5, E+9
      res_ready = 1; in_valid = 1; in_vec = 6'h3F;
      for (int k = 0; k < 15; k++) begin
         tick;
         if (k == 2) in_valid = 0;
         s = (k < 1) ? 1'b0 : (k < 5) ? 1'b1 : (k < 9) ? 1'b0 : 1'b1;
         chk("rep_bus", bus_vec, (k == 0) ? 8'h00 : (8'hFC | {7'd0, s}));
         chk("rep_valid", res_valid, (k == 4 || k == 8 || k == 12));
         if (res_valid) begin
            chk("rep_vec", res_vec, 6'h3F);
            chk("rep_data", res_data, 8'h4B);
         end
      end
      chk("rep_idle", busy, 0);
      res_ready = 0;
      // backpressure: one in flight, four queued, sixth held off
      in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         in_vec = bp[i];
         tick;
      end
      in_vec = bp[5];
      chk("bp_full", in_ready, 0);
      chk("bp_valid", res_valid, 1);
      chk("bp_vec", res_vec, 6'h01);
      chk("bp_data", res_data, 8'h01);
      chk("bp_bus", bus_vec, 8'h04);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("bp_hold_ready", in_ready, 0);
         chk("bp_hold_valid", res_valid, 1);
         chk("bp_hold_data", res_data, 8'h01);
         chk("bp_hold_bus", bus_vec, 8'h04);
      end
      res_ready = 1; n = 0; acc5 = 0;
      for (int c = 0; c < 80 && n < 6; c++) begin
         acc = in_valid && in_ready;
         if (res_valid) begin
            chk("bp_drain_vec", res_vec, bp[n]);
            chk("bp_drain_data", res_data, bpr[n]);
            n++;
         end
         tick;
         if (acc) begin
            in_valid = 0;
            acc5 = 1;
         end
      end
      chk("bp_count", n, 6);
      chk("bp_sixth_accepted", acc5, 1);
      chk("bp_idle", busy, 0);
      res_ready = 0;
      // random traffic against a queue model
      t0 = tog; np = 0; nr = 0;
      for (int c = 0; c < 3000 && nr < 20; c++) begin
         in_valid  = (np < 20) && ($urandom_range(0, 1) == 1);
         in_vec    = 6'($urandom);
         res_ready = $urandom_range(0, 1) == 1;
         if (in_valid && in_ready) begin
            q.push_back(in_vec);
            np++;
         end
         if (res_valid && res_ready) begin
            chk("rnd_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("rnd_vec", res_vec, e);
               chk("rnd_data", res_data, mm(e));
            end
            nr++;
         end
         tick;
      end
      in_valid = 0; res_ready = 0;
      chk("rnd_results", nr, 20);
      chk("rnd_toggles", tog - t0, 20);
      chk("rnd_idle", busy, 0);
      // one-cycle settle build: result after E+2, one result every two cycles
      in_valid1 = 1; in_vec1 = 6'h02; tick;
      in_vec1 = 6'h05; tick;
      in_valid1 = 0;
      chk("s1_bus0", bus_vec1, 8'h09);
      chk("s1_early", res_valid1, 0);
      tick;
      chk("s1_valid0", res_valid1, 1);
      chk("s1_data0", res_data1, 8'h12);
      chk("s1_vec0", res_vec1, 6'h02);
      tick;
      chk("s1_gap", res_valid1, 0);
      chk("s1_bus1", bus_vec1, 8'h14);
      tick;
      chk("s1_valid1", res_valid1, 1);
      chk("s1_data1", res_data1, 8'h25);
      chk("s1_vec1", res_vec1, 6'h05);
      tick;
      chk("s1_idle", busy1, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
